cache_refill_ctrl: RTL and testbench
====================================

Name: cache_refill_ctrl

Overview:
- Sequences the shared cache line adapter and the single main-memory word port on behalf of two cache requesters: requester 0 is the I-cache, requester 1 is the D-cache.
- Arbitrates misses round-robin, optionally writes back a dirty victim line, then fills the line through the adapter.
- Streams the assembled line into the granted cache and pulses that cache's done.
- Sits between both L1 caches and the memory bus.

Parameters:
- WORD_SIZE, 32, data/address width in bits.
- WORDS_PER_LINE, 8, words per cache line (power of two, ≥2); LINE_BITS = clog2(WORDS_PER_LINE).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- miss  in  2  per-requester miss request, level, held until done.
- miss_addr0, miss_addr1  in  WORD_SIZE  missing address, any byte within the line.
- dirty  in  2  per-requester: victim line must be written back first.
- victim_addr0, victim_addr1  in  WORD_SIZE  victim line address.
- wb_data0, wb_data1  in  WORD_SIZE  victim word at index word_idx, combinational from the cache.
- grant  out  2  one-hot; held from grant cycle through DONE.
- word_idx  out  LINE_BITS  word index for WB read / XFER write.
- line_we  out  2  one-hot cache line write strobe during XFER.
- done  out  2  one-cycle one-hot completion pulse.
- mem_req  out  1  memory word request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  WORD_SIZE  word-aligned memory address.
- mem_wdata  out  WORD_SIZE  write data.
- mem_rdata  in  WORD_SIZE  read data, valid with mem_ack.
- mem_ack  in  1  word accepted/returned; sampled only while mem_req=1.
- ad_clr, ad_next, ad_we  out  1  adapter counter clear / advance / buffer write.
- ad_addr  out  WORD_SIZE  line address to adapter (latched miss address).
- ad_data  out  WORD_SIZE  write data to adapter (= mem_rdata).
- ad_addr_o  in  WORD_SIZE  adapter-generated word address.
- ad_full  in  1  adapter counter at last word.

Behaviour:
- Reset (rst=1 at edge): state=IDLE, rr_ptr=0, idx=0, grant latch=0.
  - While rst=1, all outputs are 0 except ad_clr=1.
  - Reset mid-transaction abandons it: no done pulse; partial memory writes are not undone.
- State IDLE: if miss≠0, grant one requester.
  - If only one bit is set, grant that requester.
  - If both are set, grant the requester indexed by rr_ptr.
  - In the grant cycle, ad_clr=1 and miss_addr/victim_addr/dirty of the winner are latched.
  - Next state is WB if dirty[winner], else FILL.
- State WB:
  - Outputs: mem_req=1, mem_we=1, mem_addr={victim[WORD_SIZE-1:LINE_BITS+2], idx, 2'b00}, mem_wdata=wb_data[winner], word_idx=idx.
  - On mem_ack, idx++.
  - On mem_ack with idx=WORDS_PER_LINE-1, idx←0 and go to FILL.
- State FILL:
  - Outputs: mem_req=1, mem_we=0, mem_addr=ad_addr_o, ad_addr=latched miss_addr.
  - On mem_ack, same cycle: ad_we=1 and ad_next=1, with ad_data=mem_rdata.
  - On mem_ack with ad_full=1, go to XFER; the adapter counter wraps to 0.
- State XFER: one word per cycle, no stall.
  - Outputs: line_we[winner]=1, word_idx=idx, ad_next=1; the cache captures the adapter data_o.
  - idx increments each cycle; when idx=WORDS_PER_LINE-1, idx←0 and go to DONE.
- State DONE: done[winner]=1 for one cycle; rr_ptr←~winner; go to IDLE.
  - A new grant happens no earlier than the following cycle.
- Outputs not named in a state are 0. grant holds the latched winner in WB/FILL/XFER/DONE and is 0 in IDLE, except in the grant cycle, where it shows the winner.
- mem_req stays high across ack-less cycles; mem_addr and mem_wdata are stable until ack.
- Changes to miss/addresses after grant are ignored until IDLE.
- Latency with mem_ack every cycle:
  - Clean miss: grant→done = 1 + N + N + 1 cycles (18 for N=8).
  - Dirty miss: adds N cycles.

Test Plan:
- Clean miss, requester 1, addr 0x0000_1234, mem_ack every cycle → mem_addr reads 0x1220..0x123C in order; 8 ad_we pulses; line_we=2'b10 for 8 cycles with word_idx 0..7; done=2'b10 exactly 18 cycles after grant.
- Dirty miss, requester 1, victim 0x0000_4000, miss 0x0000_8010 → 8 writes 0x4000..0x401C carrying wb_data1 per word_idx, then reads 0x8000..0x801C, then XFER; done after 26 cycles.
- Both miss the same cycle after reset → requester 0 served first, then requester 1; a third concurrent pair serves 0 again (rr alternates).
- mem_ack withheld 3 cycles on fill word 2 → mem_addr and mem_req held at 0x…08; no ad_next during stall; total latency +3.
- rst asserted during FILL word 5 → next cycle state IDLE, all outputs 0, ad_clr=1; a fresh miss then fills from word 0 correctly.
- miss deasserted mid-FILL → transaction still completes and done pulses.

Source files
------------

// File: rtl/cache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cache_refill_ctrl
// Description : Two-requester (I-cache / D-cache) line refill sequencer.
//               Grants misses round-robin, writes back a dirty victim line
//               word by word, fills the line through the shared adapter and
//               then streams the assembled line into the granted cache.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_refill_ctrl #(
    parameter int WORD_SIZE      = 32,
    parameter int WORDS_PER_LINE = 8,
    localparam int LINE_BITS     = $clog2(WORDS_PER_LINE)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           miss,
    input  logic [WORD_SIZE-1:0] miss_addr0,
    input  logic [WORD_SIZE-1:0] miss_addr1,
    input  logic [1:0]           dirty,
    input  logic [WORD_SIZE-1:0] victim_addr0,
    input  logic [WORD_SIZE-1:0] victim_addr1,
    input  logic [WORD_SIZE-1:0] wb_data0,
    input  logic [WORD_SIZE-1:0] wb_data1,
    output logic [1:0]           grant,
    output logic [LINE_BITS-1:0] word_idx,
    output logic [1:0]           line_we,
    output logic [1:0]           done,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    input  logic                 mem_ack,
    output logic                 ad_clr,
    output logic                 ad_next,
    output logic                 ad_we,
    output logic [WORD_SIZE-1:0] ad_addr,
    output logic [WORD_SIZE-1:0] ad_data,
    input  logic [WORD_SIZE-1:0] ad_addr_o,
    input  logic                 ad_full
);

    localparam int                   TAG_BITS = WORD_SIZE - LINE_BITS - 2;
    localparam logic [LINE_BITS-1:0] LAST_IDX = LINE_BITS'(WORDS_PER_LINE - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WB   = 3'd1,
        S_FILL = 3'd2,
        S_XFER = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                 state;
    logic                   rr_ptr;
    logic                   win;
    logic [LINE_BITS-1:0]   idx;
    logic [WORD_SIZE-1:0]   miss_line;
    logic [TAG_BITS-1:0]    victim_tag;
    logic                   pick;
    logic [1:0]             win_oh;

    // Arbitration: a lone request wins outright, a tie goes to rr_ptr
    always_comb begin
        pick = (miss == 2'b11) ? rr_ptr : miss[1];
    end

    assign win_oh = {win, ~win};

    // Sequencer state, word index and per-transaction latches
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            rr_ptr     <= 1'b0;
            win        <= 1'b0;
            idx        <= '0;
            miss_line  <= '0;
            victim_tag <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|miss) begin
                        win        <= pick;
                        idx        <= '0;
                        miss_line  <= pick ? miss_addr1 : miss_addr0;
                        victim_tag <= pick ? victim_addr1[WORD_SIZE-1:LINE_BITS+2]
                                           : victim_addr0[WORD_SIZE-1:LINE_BITS+2];
                        state      <= dirty[pick] ? S_WB : S_FILL;
                    end
                end
                S_WB: begin
                    if (mem_ack) begin
                        if (idx == LAST_IDX) begin
                            idx   <= '0;
                            state <= S_FILL;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                S_FILL: begin
                    // The adapter owns the fill word count; its counter wraps on the last word
                    if (mem_ack && ad_full) begin
                        state <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (idx == LAST_IDX) begin
                        idx   <= '0;
                        state <= S_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_DONE: begin
                    rr_ptr <= ~win;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Output decode; reset forces everything quiet except the adapter clear
    always_comb begin
        grant     = 2'b00;
        word_idx  = '0;
        line_we   = 2'b00;
        done      = 2'b00;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        ad_clr    = 1'b0;
        ad_next   = 1'b0;
        ad_we     = 1'b0;
        ad_addr   = '0;
        ad_data   = '0;
        if (rst) begin
            ad_clr = 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|miss) begin
                        grant  = {pick, ~pick};
                        ad_clr = 1'b1;
                    end
                end
                S_WB: begin
                    grant     = win_oh;
                    mem_req   = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = {victim_tag, idx, 2'b00};
                    mem_wdata = win ? wb_data1 : wb_data0;
                    word_idx  = idx;
                end
                S_FILL: begin
                    grant    = win_oh;
                    mem_req  = 1'b1;
                    mem_addr = ad_addr_o;
                    ad_addr  = miss_line;
                    ad_data  = mem_rdata;
                    ad_we    = mem_ack;
                    ad_next  = mem_ack;
                end
                S_XFER: begin
                    grant    = win_oh;
                    line_we  = win_oh;
                    word_idx = idx;
                    ad_next  = 1'b1;
                end
                S_DONE: begin
                    grant = win_oh;
                    done  = win_oh;
                end
                default: begin
                    grant = 2'b00;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_refill_ctrl
// Description : Self-checking bench for cache_refill_ctrl. Models memory, the
//               line adapter and both caches, and checks each transaction
//               against an expected list of memory operations and line data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_refill_ctrl;

    localparam int W  = 32;
    localparam int N  = 8;
    localparam int LB = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    miss, dirty;
    logic [W-1:0]  m_addr [2];
    logic [W-1:0]  v_addr [2];
    logic [W-1:0]  wb_data0, wb_data1;
    logic [1:0]    grant, line_we, done;
    logic [LB-1:0] word_idx;
    logic          mem_req, mem_we, mem_ack;
    logic [W-1:0]  mem_addr, mem_wdata, mem_rdata;
    logic          ad_clr, ad_next, ad_we, ad_full;
    logic [W-1:0]  ad_addr, ad_data, ad_addr_o;

    always #5 clk = ~clk;

    cache_refill_ctrl #(.WORD_SIZE(W), .WORDS_PER_LINE(N)) dut (
        .clk(clk), .rst(rst), .miss(miss),
        .miss_addr0(m_addr[0]), .miss_addr1(m_addr[1]), .dirty(dirty),
        .victim_addr0(v_addr[0]), .victim_addr1(v_addr[1]),
        .wb_data0(wb_data0), .wb_data1(wb_data1),
        .grant(grant), .word_idx(word_idx), .line_we(line_we), .done(done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .ad_clr(ad_clr), .ad_next(ad_next), .ad_we(ad_we), .ad_addr(ad_addr),
        .ad_data(ad_data), .ad_addr_o(ad_addr_o), .ad_full(ad_full)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- memory and cache content models ----------------
    logic [W-1:0] wmem [logic [W-1:0]];

    function automatic logic [W-1:0] mem_val(input logic [W-1:0] a);
        if (wmem.exists(a)) return wmem[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
    endfunction

    function automatic logic [W-1:0] wb_fn(input int k, input logic [W-1:0] a);
        return (a * 32'h0100_0193) ^ ((k != 0) ? 32'hF0F0_0000 : 32'h0F0F_0000);
    endfunction

    assign wb_data0 = wb_fn(0, {v_addr[0][W-1:LB+2], word_idx, 2'b00});
    assign wb_data1 = wb_fn(1, {v_addr[1][W-1:LB+2], word_idx, 2'b00});

    // ---------------- line adapter model ----------------
    logic [LB-1:0] acnt;
    logic [W-1:0]  abuf [N];
    logic          s_clr, s_next, s_we;
    logic [W-1:0]  s_data;

    assign ad_addr_o = {ad_addr[W-1:LB+2], acnt, 2'b00};
    assign ad_full   = (acnt == LB'(N - 1));

    always @(negedge clk) begin
        s_clr  = ad_clr;
        s_next = ad_next;
        s_we   = ad_we;
        s_data = ad_data;
    end

    always @(posedge clk) begin
        if (s_we) abuf[acnt] <= s_data;
        if (s_clr) acnt <= '0;
        else if (s_next) acnt <= acnt + 1'b1;
    end

    // ---------------- transaction-level reference model ----------------
    typedef struct {
        bit           we;
        logic [W-1:0] addr;
        logic [W-1:0] data;
        int           idx;
    } op_t;

    op_t          ops[$];
    int           served[$];
    bit           active = 0;
    int           w = 0;
    int           rr = 0;
    int           xcnt, gcyc, stalls, ndone = 0;
    bit           dirty_w;
    logic [W-1:0] exp_line [N];
    logic [1:0]   done_seen = 2'b00;

    task automatic start_txn();
        logic [W-1:0] line, vline;
        op_t o;
        w       = (miss == 2'b11) ? rr : (miss[1] ? 1 : 0);
        line    = m_addr[w] & ~32'h1F;
        vline   = v_addr[w] & ~32'h1F;
        dirty_w = dirty[w];
        ops.delete();
        for (int i = 0; i < N; i++) begin
            exp_line[i] = mem_val(line + 32'(4 * i));
            if (dirty_w && vline == line) exp_line[i] = wb_fn(w, vline + 32'(4 * i));
        end
        if (dirty_w) begin
            for (int i = 0; i < N; i++) begin
                o.we = 1; o.addr = vline + 32'(4 * i); o.data = wb_fn(w, o.addr); o.idx = i;
                ops.push_back(o);
            end
        end
        for (int i = 0; i < N; i++) begin
            o.we = 0; o.addr = line + 32'(4 * i); o.data = 0; o.idx = i;
            ops.push_back(o);
        end
        check("grant_pick", 64'(grant), 64'(1 << w));
        check("grant_clr", 64'(ad_clr), 64'd1);
        check("grant_quiet", 64'({done, line_we, mem_req}), 64'd0);
        active = 1; gcyc = cyc; stalls = 0; xcnt = 0;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            check("rst_outs", 64'(|{grant, word_idx, line_we, done, mem_req, mem_we, mem_addr,
                                    mem_wdata, ad_next, ad_we, ad_addr, ad_data}), 64'd0);
            check("rst_clr", 64'(ad_clr), 64'd1);
            active = 0; rr = 0; ops.delete();
        end else if (!active) begin
            if (miss != 2'b00) start_txn();
            else check("idle_quiet", 64'({grant, mem_req, line_we, done, ad_clr, ad_next, ad_we}), 64'd0);
        end else begin
            check("grant_hold", 64'(grant), 64'(1 << w));
            if (mem_req) begin
                check("mem_only", 64'({line_we, done}), 64'd0);
                if (ops.size() == 0) begin
                    check("mem_req_extra", 64'd1, 64'd0);
                end else begin
                    check("mem_we", 64'(mem_we), 64'(ops[0].we));
                    check("mem_addr", 64'(mem_addr), 64'(ops[0].addr));
                    if (ops[0].we) begin
                        check("wb_data", 64'(mem_wdata), 64'(ops[0].data));
                        check("wb_idx", 64'(word_idx), 64'(ops[0].idx));
                    end else begin
                        check("fill_strobes", 64'({ad_we, ad_next}), mem_ack ? 64'd3 : 64'd0);
                        if (mem_ack) check("ad_data", 64'(ad_data), 64'(mem_val(mem_addr)));
                    end
                    if (mem_ack) begin
                        if (ops[0].we) wmem[ops[0].addr] = ops[0].data;
                        void'(ops.pop_front());
                    end else begin
                        stalls++;
                    end
                end
            end else if (line_we != 2'b00) begin
                check("line_we", 64'(line_we), 64'(1 << w));
                check("xfer_idx", 64'(word_idx), 64'(xcnt));
                check("xfer_next", 64'(ad_next), 64'd1);
                check("xfer_ops_left", 64'(ops.size()), 64'd0);
                check("line_data", 64'(abuf[acnt]), 64'(exp_line[xcnt % N]));
                xcnt++;
            end else if (done != 2'b00) begin
                check("done", 64'(done), 64'(1 << w));
                check("xfer_count", 64'(xcnt), 64'(N));
                check("latency", 64'(cyc - gcyc + 1), 64'(2 + 2 * N + (dirty_w ? N : 0) + stalls));
                done_seen[w] = 1'b1;
                served.push_back(w);
                rr = 1 - w; active = 0; ndone++;
            end else begin
                check("stray_cycle", 64'd1, 64'd0);
            end
        end
    end

    // ---------------- stimulus ----------------
    bit auto_miss = 0;
    bit stall_mode = 0;
    int stall_n = 0;
    int ack_pct = 100;

    task automatic drive();
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (done_seen[k]) begin miss[k] = 1'b0; done_seen[k] = 1'b0; end
            if (auto_miss) begin
                if (!miss[k] && !(active && w == k) && $urandom_range(99) < 40) begin
                    miss[k]   = 1'b1;
                    m_addr[k] = $urandom & 32'h000F_FFFF;
                    v_addr[k] = $urandom & 32'h000F_FFFF;
                    dirty[k]  = $urandom_range(1) == 1;
                end else if (miss[k] && active && w == k) begin
                    if ($urandom_range(99) < 20) m_addr[k] = $urandom;
                    if ($urandom_range(99) < 3)  miss[k] = 1'b0;
                end
            end
        end
        if (stall_mode && ops.size() > 0 && !ops[0].we && ops[0].idx == 2 && stall_n < 3) begin
            mem_ack = 1'b0; stall_n++;
        end else begin
            mem_ack = $urandom_range(99) < ack_pct;
        end
        mem_rdata = mem_val(mem_addr);
    endtask

    task automatic wait_done(input int target, input int budget);
        int b = budget;
        while (ndone < target && b > 0) begin drive(); b--; end
        if (ndone < target) check("timeout_done", 64'd0, 64'd1);
    endtask

    task automatic wait_fill(input int idx);
        int b = 200;
        while (!(active && ops.size() > 0 && !ops[0].we && ops[0].idx == idx) && b > 0) begin
            drive(); b--;
        end
        if (b == 0) check("timeout_fill", 64'd0, 64'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1; drive(); drive(); rst = 1'b0;
    endtask

    task automatic req(input int k, input logic [W-1:0] ma, input logic [W-1:0] va, input bit d);
        m_addr[k] = ma; v_addr[k] = va; dirty[k] = d; miss[k] = 1'b1;
    endtask

    initial begin
        rst = 1'b1; miss = 2'b00; dirty = 2'b00; mem_ack = 1'b0; mem_rdata = '0;
        m_addr[0] = '0; m_addr[1] = '0; v_addr[0] = '0; v_addr[1] = '0;
        repeat (3) drive();
        rst = 1'b0;
        drive();

        // clean miss, requester 1
        req(1, 32'h0000_1234, 32'h0, 0);
        wait_done(ndone + 1, 60);
        // dirty miss, requester 1
        drive();
        req(1, 32'h0000_8010, 32'h0000_4000, 1);
        wait_done(ndone + 1, 60);

        // concurrent pairs after reset: 0, 1, then 0 again
        do_reset();
        served.delete();
        req(0, 32'h0000_2040, 32'h0, 0);
        req(1, 32'h0000_3080, 32'h0, 0);
        wait_done(ndone + 2, 100);
        drive();
        req(0, 32'h0000_5000, 32'h0, 0);
        req(1, 32'h0000_6000, 32'h0, 0);
        wait_done(ndone + 2, 100);
        if (served.size() >= 3) begin
            check("rr_first", 64'(served[0]), 64'd0);
            check("rr_second", 64'(served[1]), 64'd1);
            check("rr_third", 64'(served[2]), 64'd0);
        end else begin
            check("rr_served", 64'(served.size()), 64'd3);
        end

        // fill word 2 stalled three cycles
        drive();
        stall_mode = 1; stall_n = 0;
        req(0, 32'h0000_7008, 32'h0, 0);
        wait_done(ndone + 1, 60);
        check("stall_seen", 64'(stall_n), 64'd3);
        stall_mode = 0;

        // reset during fill word 5, then a fresh fill of the held miss
        drive();
        req(0, 32'h0000_9100, 32'h0, 0);
        wait_fill(5);
        rst = 1'b1; drive(); rst = 1'b0;
        wait_done(ndone + 1, 60);

        // miss withdrawn mid-fill still completes
        drive();
        req(1, 32'h0000_A200, 32'h0000_B300, 1);
        wait_fill(3);
        miss[1] = 1'b0;
        wait_done(ndone + 1, 60);

        // randomized traffic with random ack gaps
        ack_pct = 70; auto_miss = 1;
        repeat (3000) drive();
        auto_miss = 0;
        begin
            int b = 1000;
            while ((miss != 2'b00 || active) && b > 0) begin drive(); b--; end
            if (b == 0) check("timeout_drain", 64'd0, 64'd1);
        end
        repeat (3) drive();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
